// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. It produces one round key per clock after start
// and holds all 11 keys for random-access reads by the encrypt round datapath.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         ready
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         r_state;
  state_t         w_stateNext;
  logic           w_accept;
  logic           w_step;
  logic           w_last;

  logic [127:0]   r_rk [0:10];
  logic [3:0]     r_cnt;
  logic [7:0]     r_rcon;
  logic           r_busy;
  logic           r_ready;
  logic           r_rkValid;
  logic [3:0]     r_rkIdx;

  logic [3:0]     w_prevIdx;
  logic [127:0]   w_prev;
  logic [31:0]    w_rot;
  logic [31:0]    w_t;
  logic [31:0]    w_w0;
  logic [31:0]    w_w1;
  logic [31:0]    w_w2;
  logic [31:0]    w_w3;
  logic [127:0]   w_nextKey;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = EXPAND;
        end
      end
      EXPAND: begin
        w_step = 1'b1;
        if (r_cnt == 4'(NUM_ROUNDS)) begin
          w_last      = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // One key-schedule round from the previously written key.
  assign w_prevIdx = r_cnt - 4'd1;

  always_comb begin
    w_prev = '0;
    if (w_prevIdx <= 4'd10) w_prev = r_rk[w_prevIdx];
  end

  assign w_rot     = {w_prev[23:0], w_prev[31:24]};
  assign w_t       = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]}
                     ^ {r_rcon, 24'h0};
  assign w_w0      = w_prev[127:96] ^ w_t;
  assign w_w1      = w_prev[95:64]  ^ w_w0;
  assign w_w2      = w_prev[63:32]  ^ w_w1;
  assign w_w3      = w_prev[31:0]   ^ w_w2;
  assign w_nextKey = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
      r_cnt     <= '0;
      r_rcon    <= 8'h01;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_rkValid <= 1'b0;
      r_rkIdx   <= '0;
    end else begin
      r_rkValid <= 1'b0;
      if (w_accept) begin
        r_rk[0]   <= key;
        r_rcon    <= 8'h01;
        r_cnt     <= 4'd1;
        r_busy    <= 1'b1;
        r_ready   <= 1'b0;
        r_rkValid <= 1'b1;
        r_rkIdx   <= 4'd0;
      end else if (w_step) begin
        r_rk[r_cnt] <= w_nextKey;
        r_rcon      <= xtime(r_rcon);
        r_cnt       <= r_cnt + 4'd1;
        r_rkValid   <= 1'b1;
        r_rkIdx     <= r_cnt;
        if (w_last) begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      end
    end
  end

  // Unused indices read as zero so a stray select never aliases a real key.
  always_comb begin
    round_key = '0;
    if (round_sel <= 4'd10) round_key = r_rk[round_sel];
  end

  assign rk_valid = r_rkValid;
  assign rk_idx   = r_rkIdx;
  assign busy     = r_busy;
  assign ready    = r_ready;

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. It sits directly upstream of the encrypt round datapath and supplies round keys 0..10 to its AddRoundKey steps.
- It generates one round key per clock after a start pulse and holds all 11 keys in registers. The round datapath reads any key by index.
- Byte and word order match the encrypt datapath: w0 = key[127:96], and byte 0 of each word is bits [31:24].

Parameters:
NUM_ROUNDS, 10, number of generated round keys after key 0 (fixed 10 for AES-128; other values unsupported)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to expand key; sampled on rising clk
key  input  128  cipher key, sampled only in the cycle start is accepted
round_sel  input  4  index of round key presented on round_key
round_key  output  128  combinational read of stored round key [round_sel]
rk_valid  output  1  registered pulse, high one cycle each time a round key is written
rk_idx  output  4  index of the key written, valid with rk_valid
busy  output  1  expansion in progress
ready  output  1  all 11 keys valid and stable

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; busy=0, ready=0, rk_valid=0, rk_idx=0.
  - All 11 key registers are cleared to 0, round counter=0, rcon=8'h01.
- States: IDLE, EXPAND.
- IDLE, start=1 at edge E:
  - rk[0] <= key, rcon <= 01, counter <= 1, ready <= 0, busy <= 1, rk_valid <= 1, rk_idx <= 0.
  - Go to EXPAND.
- EXPAND, each edge, computes rk[counter] from rk[counter-1]=(w0..w3):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}. RotWord = {w3[23:0],w3[31:24]}. SubWord applies the standard AES S-box per byte.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - rk_valid<=1, rk_idx<=counter.
  - rcon <= xtime(rcon): left shift, XOR 8'h1b if msb was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - counter increments.
- Completion: when counter==NUM_ROUNDS, that edge writes rk[10], sets busy<=0 and ready<=1, and returns to IDLE.
- Latency: start accepted at edge E. rk[n] is written at edge E+n. ready is high after edge E+10.
- Throughput: one expansion per 11 cycles; back-to-back start in the cycle after ready is allowed.
- start while busy=1: ignored; no restart, no error.
- start while ready=1 (IDLE): accepted. ready drops at that edge and the old keys are overwritten progressively.
- rk_valid is low in every cycle in which no key is written.
- round_key:
  - Pure combinational mux of stored registers.
  - round_sel > 10 returns 128'h0.
  - Reads while busy return whatever is currently stored; the consumer must wait for ready, or for rk_valid with matching rk_idx.
- key input is ignored except at the accepting edge.
- reset_n asserted mid-expansion: immediate abort to the reset state. No partial ready.
- S-box: four combinational 256-entry lookups (one per byte of w3). Table values per FIPS-197.

Test Plan:
- Reset mid-operation:
  - Pulse start, then assert reset_n low at edge E+4 → busy=0, ready=0, rk_valid=0 immediately.
  - round_key for sel 0..10 all 0.
- FIPS-197 vector: key=2b7e151628aed2a6abf7158809cf4f3c, start at E.
  - ready high after E+10.
  - rk[0]=key; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_valid high 11 consecutive cycles with rk_idx 0..10.
- All-zero key:
  - rk[1]=62636363626363636263636362636363.
  - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- start asserted at E+3 during expansion → ignored. Results identical to the FIPS vector; ready still after E+10.
- Back-to-back: second start with the zero key in the cycle after ready.
  - ready drops at that edge.
  - After 10 further edges rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- round_sel=11..15 → round_key=0. Changing round_sel with ready=1 → round_key changes in the same cycle, no clock required.
